flag_pulse_counter: RTL and testbench
=====================================

Name: flag_pulse_counter

Overview:
- Free-running modulo-N event counter that emits a one-cycle flag each time it completes TERMINAL enabled cycles.
- Used as a tick/period generator for downstream status and statistics logic.
- Single clock domain.
- Also provides the live count and a saturating total of flags issued.

Parameters:
WIDTH, 8, width of count register; must satisfy TERMINAL <= 2**WIDTH
TERMINAL, 10, number of enabled cycles per flag period (>=1)
TOT_W, 16, width of flag_total statistics counter

Ports:
clk  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  count-advance qualifier, sampled each rising edge
clear  input  1  synchronous soft clear of count, flag and flag_total
load  input  1  synchronous preset of count from load_val
load_val  input  WIDTH  preset value for count
count  output  WIDTH  current count value, registered
flag_count  output  1  registered one-cycle pulse at period completion
flag_total  output  TOT_W  number of flags issued, saturating, registered
flag_sticky  output  1  sticky flag indicator (see Optional Feature)

Behaviour:
- Reset values (rst=1 at a rising edge): count=0, flag_count=0, flag_total=0, flag_sticky=0. rst has priority over all other inputs.
- Priority per edge: rst > clear > load > enable.
- clear=1: count<=0, flag_count<=0, flag_total<=0, flag_sticky<=0. Same effect as rst, but a functional input.
- load=1 (clear=0):
  - count<=load_val; flag_count<=0.
  - If load_val >= TERMINAL, count<=TERMINAL-1 (clamp).
  - No flag is generated by a load.
- enable=1 (no clear/load):
  - If count==TERMINAL-1: count<=0, flag_count<=1 on that edge, flag_total<=flag_total+1.
  - Otherwise: count<=count+1, flag_count<=0.
- enable=0: count holds, flag_count<=0. flag_count is never high for two consecutive cycles unless TERMINAL=1 with enable held high.
- Latency:
  - flag_count rises on the same edge at which count wraps to 0. It is visible in the cycle in which count reads 0.
  - With enable held high from count=0, the first flag appears after exactly TERMINAL edges; thereafter one flag every TERMINAL edges.
- TERMINAL=1: count stays 0; flag_count=enable registered (high every enabled cycle).
- flag_total saturates at 2**TOT_W-1 and does not wrap.
- Mid-period reset/clear: discards the partial period. The next flag requires a full TERMINAL enabled cycles.
- Gaps in enable stretch the period; only enabled edges count.
- All outputs come directly from flops; no combinational paths from inputs to outputs.

Optional Feature:
FLAG_COUNTER_STICKY_EN
- Defined:
  - flag_sticky is set to 1 on the edge where flag_count is first set.
  - It stays 1 until rst or clear.
  - It is unaffected by load and enable.
- Undefined:
  - The flag_sticky port still exists but is tied to constant 0.
  - No sticky flop is synthesized.

Test Plan:
- Reset: rst=1 for 2 cycles with enable=1 -> count=0, flag_count=0, flag_total=0, flag_sticky=0 throughout.
- Continuous count (TERMINAL=10): release rst, enable=1 for 30 edges -> count runs 0..9; flag_count high one cycle after edges 10, 20, 30; flag_total=3.
- Enable gaps: enable toggles 1/0 each cycle -> flag asserts after 20 edges (10 enabled); count holds on disabled cycles; flag_count never high while enable was 0 on the prior edge.
- Load and clamp:
  - load=1, load_val=7, then enable=1 -> flag after 3 enabled edges.
  - load_val=200 -> count=9, flag on the next enabled edge.
- Clear mid-period: count=5, clear=1 with enable=1 -> count=0, flag_total=0, no flag; the next flag needs 10 more enabled edges.
- Sticky and saturation (TOT_W=2, macro defined): 5 full periods -> flag_total=3 (saturated); flag_sticky=1 after the first flag, 0 after clear. With the macro undefined, flag_sticky stays 0.

Source files
------------

// File: rtl/flag_pulse_counter.sv
// rtl/flag_pulse_counter.sv - modulo-TERMINAL event counter with one-cycle period flag and saturating flag total
// Optional sticky flag output is built only when FLAG_COUNTER_STICKY_EN is defined.
module flag_pulse_counter #(
   parameter int WIDTH    = 8,
   parameter int TERMINAL = 10,
   parameter int TOT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             flag_count,
   output logic [TOT_W-1:0] flag_total,
   output logic             flag_sticky
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(TERMINAL - 1);
   localparam logic [WIDTH:0]   TERM_X  = (WIDTH + 1)'(TERMINAL);
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   logic [WIDTH-1:0] count_q, count_d;
   logic             flag_q, flag_d;
   logic [TOT_W-1:0] total_q, total_d;

   always_comb begin
      count_d = count_q;
      flag_d  = 1'b0;
      total_d = total_q;
      if (clear) begin
         count_d = '0;
         total_d = '0;
      end else if (load) begin
         // TERMINAL may equal 2**WIDTH, so compare one bit wider
         count_d = ({1'b0, load_val} >= TERM_X) ? LAST : load_val;
      end else if (enable) begin
         if (count_q == LAST) begin
            count_d = '0;
            flag_d  = 1'b1;
            if (total_q != TOT_MAX) begin
               total_d = total_q + 1'b1;
            end
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
         total_q <= '0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
         total_q <= total_d;
      end
   end

`ifdef FLAG_COUNTER_STICKY_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q | flag_d;
      if (clear) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign flag_sticky = sticky_q;
`else
   assign flag_sticky = 1'b0;
`endif

   assign count      = count_q;
   assign flag_count = flag_q;
   assign flag_total = total_q;

endmodule

// File: tb/tb_flag_pulse_counter.sv
// tb/tb_flag_pulse_counter.sv - directed and randomized bench for flag_pulse_counter against a behavioural model
module tb_flag_pulse_counter;

   localparam int WIDTH    = 8;
   localparam int TERMINAL = 10;
   localparam int TOT_W    = 4;
   localparam int TOT_MAX  = (1 << TOT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             clear = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             flag_count;
   logic [TOT_W-1:0] flag_total;
   logic             flag_sticky;

   int checks = 0;
   int errors = 0;

   int m_count = 0;
   bit m_flag = 0;
   int m_total = 0;
   bit m_sticky = 0;
   bit prev_en = 0;
   bit prev_flag = 0;

   flag_pulse_counter #(.WIDTH(WIDTH), .TERMINAL(TERMINAL), .TOT_W(TOT_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
      .load_val(load_val), .count(count), .flag_count(flag_count),
      .flag_total(flag_total), .flag_sticky(flag_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Spec-level model: counts enabled edges per period with integer arithmetic.
   task automatic model_edge(input bit r, input bit c, input bit l, input int lv, input bit e);
      if (r || c) begin
         m_count = 0; m_flag = 0; m_total = 0; m_sticky = 0;
      end else if (l) begin
         m_count = (lv >= TERMINAL) ? TERMINAL - 1 : lv;
         m_flag = 0;
      end else if (e) begin
         m_count = (m_count + 1) % TERMINAL;
         m_flag = (m_count == 0);
         if (m_flag) begin
            if (m_total < TOT_MAX) m_total++;
`ifdef FLAG_COUNTER_STICKY_EN
            m_sticky = 1;
`endif
         end
      end else begin
         m_flag = 0;
      end
   endtask

   task automatic cycle(input bit r, input bit c, input bit l, input int lv, input bit e);
      bit en_live;
      rst = r; clear = c; load = l; load_val = WIDTH'(lv); enable = e;
      en_live = e && !r && !c && !l;
      @(posedge clk);
      model_edge(r, c, l, lv, e);
      #1;
      check("count", 16'(count), 16'(m_count));
      check("flag_count", 16'(flag_count), 16'(m_flag));
      check("flag_total", 16'(flag_total), 16'(m_total));
      check("flag_sticky", 16'(flag_sticky), 16'(m_sticky));
      if (flag_count) check("flag_needs_enable", 16'(en_live), 16'd1);
      if (flag_count && prev_flag) check("flag_double", 16'(flag_count), 16'd0);
      prev_en = en_live;
      prev_flag = flag_count;
   endtask

   initial begin
      int r;
      // reset held two cycles with enable high
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 1);
      check("reset_count", 16'(count), 16'd0);
      check("reset_total", 16'(flag_total), 16'd0);

      // continuous counting: three full periods
      for (int i = 1; i <= 30; i++) begin
         cycle(0, 0, 0, 0, 1);
         check("cont_flag_pos", 16'(flag_count), 16'((i % 10) == 0));
      end
      check("cont_total", 16'(flag_total), 16'd3);

      // alternating enable: one flag after 20 edges
      for (int i = 1; i <= 20; i++) cycle(0, 0, 0, 0, i % 2);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      check("gap_total", 16'(flag_total), 16'd4);

      // load 7 then three enabled edges to a flag
      cycle(0, 0, 1, 7, 1);
      check("load7_count", 16'(count), 16'd7);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check("load7_noflag", 16'(flag_count), 16'd0);
      cycle(0, 0, 0, 0, 1);
      check("load7_flag", 16'(flag_count), 16'd1);

      // load beyond terminal clamps to TERMINAL-1
      cycle(0, 0, 1, 200, 0);
      check("clamp_count", 16'(count), 16'd9);
      check("clamp_noflag", 16'(flag_count), 16'd0);
      cycle(0, 0, 0, 0, 1);
      check("clamp_flag", 16'(flag_count), 16'd1);

      // clear mid-period
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
      check("pre_clear_count", 16'(count), 16'd5);
      cycle(0, 1, 0, 0, 1);
      check("clear_count", 16'(count), 16'd0);
      check("clear_total", 16'(flag_total), 16'd0);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1);
      check("clear_noflag", 16'(flag_count), 16'd0);
      cycle(0, 0, 0, 0, 1);
      check("clear_flag", 16'(flag_count), 16'd1);

      // saturation of flag_total
      for (int i = 0; i < 10 * (TOT_MAX + 2); i++) cycle(0, 0, 0, 0, 1);
      check("sat_total", 16'(flag_total), 16'(TOT_MAX));
`ifdef FLAG_COUNTER_STICKY_EN
      check("sticky_set", 16'(flag_sticky), 16'd1);
`else
      check("sticky_tied", 16'(flag_sticky), 16'd0);
`endif
      cycle(0, 1, 0, 0, 0);
      check("sticky_clear", 16'(flag_sticky), 16'd0);

      // randomized control mix
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 999);
         cycle(r < 3, (r >= 3) && (r < 6), (r >= 6) && (r < 40),
               $urandom_range(0, 255), $urandom_range(0, 9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
